// File: rtl/tag_pattern_generator_pkg.sv
// Shared definitions for the tag pattern generator.
// Holds the register map, the FSM state encoding, the reset values and the channel limit.
// Optional build macro TAG_GEN_JITTER_EN enables the LFSR jitter helpers.
package tag_pattern_generator_pkg;

    // Register word addresses
    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_CHANNEL  = 4'd1;
    localparam logic [3:0] ADDR_PERIOD   = 4'd2;
    localparam logic [3:0] ADDR_COUNT    = 4'd3;
    localparam logic [3:0] ADDR_START_LO = 4'd4;
    localparam logic [3:0] ADDR_START_HI = 4'd5;
    localparam logic [3:0] ADDR_TPW      = 4'd6;
    localparam logic [3:0] ADDR_EMITTED  = 4'd7;

    // Period after reset: 1 ns in 1/3 ps units
    localparam logic [31:0] PERIOD_RESET = 32'd3000;

    // Largest channel magnitude (+1..+18 rising, -1..-18 falling)
    localparam logic signed [31:0] CHANNEL_LIMIT = 32'sd18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Tags-per-word after reset: a full output word
    function automatic logic [31:0] tpw_reset(input int word_width);
        return 32'(word_width);
    endfunction

    // A channel value is usable when it is nonzero and within +/-CHANNEL_LIMIT
    function automatic logic channel_valid(input logic [31:0] value);
        logic signed [31:0] v;
        v = value;
        return (v != 32'sd0) && (v <= CHANNEL_LIMIT) && (v >= -CHANNEL_LIMIT);
    endfunction

`ifdef TAG_GEN_JITTER_EN
    localparam logic [15:0] LFSR_SEED         = 16'hACE1;
    localparam logic [31:0] PERIOD_MIN_JITTER = 32'd16;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // 4-bit jitter offset for a slot, taken from a rotating nibble of the LFSR state
    function automatic logic [3:0] jitter_nibble(input logic [15:0] s, input int slot);
        logic [15:0] t;
        t = s >> (4 * (slot % 4));
        return t[3:0];
    endfunction
`endif

endpackage

// File: rtl/wb_interface.sv
// Classic single-cycle Wishbone bus, word addressed, 32-bit data.
interface wb_interface;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (output cyc, output stb, output we, output adr, output dat_w,
                    input dat_r, input ack);
    modport slave  (input cyc, input stb, input we, input adr, input dat_w,
                    output dat_r, output ack);
endinterface

// File: rtl/tag_pattern_generator_regs.sv
// tag_gen_regs: Wishbone register file of the tag pattern generator.
// Produces one-cycle START/STOP pulses from CTRL writes and blocks configuration
// writes while the generator is busy.
// Optional build macro TAG_GEN_JITTER_EN rejects PERIOD values below 16.
module tag_gen_regs #(
    parameter int WORD_WIDTH    = 4,
    parameter int RESET_CHANNEL = 1
) (
    input  logic               clk,
    input  logic               rst,
    wb_interface.slave         wb,
    input  logic               i_busy,
    input  logic [31:0]        i_emitted,
    output logic               o_start,
    output logic               o_stop,
    output logic signed [5:0]  o_channel,
    output logic [31:0]        o_period,
    output logic [31:0]        o_count,
    output logic [63:0]        o_start_time,
    output logic [31:0]        o_tpw
);
    import tag_pattern_generator_pkg::*;

    logic              r_ack;
    logic [31:0]       r_dat_r;
    logic              r_start;
    logic              r_stop;
    logic signed [5:0] r_channel;
    logic [31:0]       r_period;
    logic [31:0]       r_count;
    logic [31:0]       r_start_lo;
    logic [31:0]       r_start_hi;
    logic [31:0]       r_tpw;
    logic              w_access;
    logic              w_wr;
    logic [31:0]       w_rdata;

    // A new access is one not yet acknowledged; ack follows one cycle later
    assign w_access = wb.cyc & wb.stb & ~r_ack;
    assign w_wr     = w_access & wb.we;

    // Read data multiplexer
    always_comb begin
        w_rdata = 32'd0;
        case (wb.adr)
            ADDR_CTRL:     w_rdata = {29'd0, i_busy, 2'b00};
            ADDR_CHANNEL:  w_rdata = {{26{r_channel[5]}}, r_channel};
            ADDR_PERIOD:   w_rdata = r_period;
            ADDR_COUNT:    w_rdata = r_count;
            ADDR_START_LO: w_rdata = r_start_lo;
            ADDR_START_HI: w_rdata = r_start_hi;
            ADDR_TPW:      w_rdata = r_tpw;
            ADDR_EMITTED:  w_rdata = i_emitted;
            default:       w_rdata = 32'd0;
        endcase
    end

    // Register writes, control pulses, ack and read data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack      <= 1'b0;
            r_dat_r    <= 32'd0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_channel  <= 6'(RESET_CHANNEL);
            r_period   <= PERIOD_RESET;
            r_count    <= 32'd0;
            r_start_lo <= 32'd0;
            r_start_hi <= 32'd0;
            r_tpw      <= tpw_reset(WORD_WIDTH);
        end else begin
            r_ack   <= w_access;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            if (w_access) begin
                r_dat_r <= w_rdata;
            end else begin
                r_dat_r <= r_dat_r;
            end
            if (w_wr) begin
                case (wb.adr)
                    ADDR_CTRL: begin
                        r_start <= wb.dat_w[0];
                        r_stop  <= wb.dat_w[1];
                    end
                    ADDR_CHANNEL: begin
                        if (!i_busy && channel_valid(wb.dat_w)) begin
                            r_channel <= wb.dat_w[5:0];
                        end
                    end
                    ADDR_PERIOD: begin
`ifdef TAG_GEN_JITTER_EN
                        if (!i_busy && (wb.dat_w >= PERIOD_MIN_JITTER)) begin
                            r_period <= wb.dat_w;
                        end
`else
                        if (!i_busy) begin
                            r_period <= wb.dat_w;
                        end
`endif
                    end
                    ADDR_COUNT: begin
                        if (!i_busy) begin
                            r_count <= wb.dat_w;
                        end
                    end
                    ADDR_START_LO: begin
                        if (!i_busy) begin
                            r_start_lo <= wb.dat_w;
                        end
                    end
                    ADDR_START_HI: begin
                        if (!i_busy) begin
                            r_start_hi <= wb.dat_w;
                        end
                    end
                    ADDR_TPW: begin
                        if (!i_busy && (wb.dat_w != 32'd0)) begin
                            if (wb.dat_w > 32'(WORD_WIDTH)) begin
                                r_tpw <= 32'(WORD_WIDTH);
                            end else begin
                                r_tpw <= wb.dat_w;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign wb.ack       = r_ack;
    assign wb.dat_r     = r_dat_r;
    assign o_start      = r_start;
    assign o_stop       = r_stop;
    assign o_channel    = r_channel;
    assign o_period     = r_period;
    assign o_count      = r_count;
    assign o_start_time = {r_start_hi, r_start_lo};
    assign o_tpw        = r_tpw;

endmodule

// File: rtl/tag_pattern_generator.sv
// tag_pattern_generator: emits words of periodic time tags on an AXI-Stream-like port.
// Each word carries up to WORD_WIDTH slots spaced by PERIOD, configured over Wishbone.
// Optional build macro TAG_GEN_JITTER_EN adds a 0..15 LFSR offset to every slot time.
module tag_pattern_generator #(
    parameter int WORD_WIDTH    = 4,
    parameter int RESET_CHANNEL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_interface.slave            wb,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [63:0]           m_axis_tagtime [WORD_WIDTH],
    output logic signed [5:0]     m_axis_channel [WORD_WIDTH],
    output logic [WORD_WIDTH-1:0] m_axis_tkeep,
    output logic [63:0]           lowest_time_bound
);
    import tag_pattern_generator_pkg::*;

    state_e                r_state;
    state_e                w_next_state;
    logic                  w_start;
    logic                  w_stop;
    logic signed [5:0]     w_cfg_channel;
    logic [31:0]           w_cfg_period;
    logic [31:0]           w_cfg_count;
    logic [63:0]           w_cfg_start_time;
    logic [31:0]           w_cfg_tpw;

    logic [63:0]           r_next_time;
    logic [31:0]           r_remaining;
    logic                  r_endless;
    logic [31:0]           r_emitted;
    logic [31:0]           r_sent;
    logic                  r_tvalid;
    logic [63:0]           r_tagtime [WORD_WIDTH];
    logic signed [5:0]     r_channel [WORD_WIDTH];
    logic [WORD_WIDTH-1:0] r_tkeep;

    logic                  w_hs;
    logic                  w_start_go;
    logic                  w_load;
    logic                  w_done;
    logic [63:0]           w_adv_time;
    logic [31:0]           w_adv_rem;
    logic [32:0]           w_emit_sum;
    logic [31:0]           w_emit_next;
    logic [63:0]           w_base;
    logic [31:0]           w_rem;
    logic                  w_endl;
    logic [31:0]           w_n;
    logic [WORD_WIDTH-1:0] w_keep;
    logic [63:0]           w_times [WORD_WIDTH];
`ifdef TAG_GEN_JITTER_EN
    logic [15:0]           r_lfsr;
    logic [15:0]           w_lfsr_use;
`endif

    tag_gen_regs #(
        .WORD_WIDTH    (WORD_WIDTH),
        .RESET_CHANNEL (RESET_CHANNEL)
    ) u_regs (
        .clk          (clk),
        .rst          (rst),
        .wb           (wb),
        .i_busy       (r_state != ST_IDLE),
        .i_emitted    (r_emitted),
        .o_start      (w_start),
        .o_stop       (w_stop),
        .o_channel    (w_cfg_channel),
        .o_period     (w_cfg_period),
        .o_count      (w_cfg_count),
        .o_start_time (w_cfg_start_time),
        .o_tpw        (w_cfg_tpw)
    );

    // Accepting the pending word moves the time base and counters by the tags it carried
    assign w_hs        = r_tvalid & m_axis_tready;
    assign w_adv_time  = r_next_time + (64'(r_sent) * {32'd0, w_cfg_period});
    assign w_adv_rem   = r_endless ? r_remaining : (r_remaining - r_sent);
    assign w_done      = !r_endless && (w_adv_rem == 32'd0);
    assign w_emit_sum  = {1'b0, r_emitted} + {1'b0, r_sent};
    assign w_emit_next = w_emit_sum[32] ? 32'hFFFF_FFFF : w_emit_sum[31:0];

`ifdef TAG_GEN_JITTER_EN
    // Each burst restarts the jitter sequence from the seed
    assign w_lfsr_use = w_start_go ? LFSR_SEED : lfsr_next(r_lfsr);
`endif

    // FSM next state and word-load decisions
    always_comb begin
        w_next_state = r_state;
        w_start_go   = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_RUN;
                    w_start_go   = 1'b1;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_hs) begin
                    if (w_stop || w_done) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_RUN;
                        w_load       = 1'b1;
                    end
                end else if (w_stop) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_hs) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Build the next word: from configuration at START, else from the advanced time base
    always_comb begin
        w_base = w_adv_time;
        w_rem  = w_adv_rem;
        w_endl = r_endless;
        w_keep = {WORD_WIDTH{1'b0}};
        if (r_state == ST_IDLE) begin
            w_base = w_cfg_start_time;
            w_rem  = w_cfg_count;
            w_endl = (w_cfg_count == 32'd0);
        end else begin
            w_base = w_adv_time;
            w_rem  = w_adv_rem;
            w_endl = r_endless;
        end
        if (w_endl || (w_rem > w_cfg_tpw)) begin
            w_n = w_cfg_tpw;
        end else begin
            w_n = w_rem;
        end
        for (int i = 0; i < WORD_WIDTH; i++) begin
            w_keep[i]  = (32'(i) < w_n);
`ifdef TAG_GEN_JITTER_EN
            w_times[i] = w_base + (64'(i) * {32'd0, w_cfg_period})
                         + {60'd0, jitter_nibble(w_lfsr_use, i)};
`else
            w_times[i] = w_base + (64'(i) * {32'd0, w_cfg_period});
`endif
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Time base, counters and the registered output word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_next_time <= 64'd0;
            r_remaining <= 32'd0;
            r_endless   <= 1'b0;
            r_emitted   <= 32'd0;
            r_sent      <= 32'd0;
            r_tvalid    <= 1'b0;
            r_tkeep     <= {WORD_WIDTH{1'b0}};
            for (int i = 0; i < WORD_WIDTH; i++) begin
                r_tagtime[i] <= 64'd0;
                r_channel[i] <= 6'sd0;
            end
        end else begin
            if (w_start_go) begin
                r_next_time <= w_cfg_start_time;
                r_remaining <= w_cfg_count;
                r_endless   <= (w_cfg_count == 32'd0);
                r_emitted   <= 32'd0;
            end else if (w_hs) begin
                r_next_time <= w_adv_time;
                r_remaining <= w_adv_rem;
                r_emitted   <= w_emit_next;
            end
            if (w_load) begin
                r_tvalid  <= 1'b1;
                r_tkeep   <= w_keep;
                r_sent    <= w_n;
                r_tagtime <= w_times;
                for (int i = 0; i < WORD_WIDTH; i++) begin
                    r_channel[i] <= w_cfg_channel;
                end
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
            end
        end
    end

`ifdef TAG_GEN_JITTER_EN
    // Jitter LFSR: seeded at reset and START, stepped once per loaded word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_load) begin
            r_lfsr <= w_lfsr_use;
        end
    end
`endif

    assign m_axis_tvalid     = r_tvalid;
    assign m_axis_tagtime    = r_tagtime;
    assign m_axis_channel    = r_channel;
    assign m_axis_tkeep      = r_tkeep;
    assign lowest_time_bound = r_next_time;

endmodule
